uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  - Oversampling async serial receiver (8N1, LSB first) on the rx_serial2jtag pin.
//  - Feeds the UART-to-JTAG-UART bridge: presents each received byte on a valid/ready pair (rx_req/rx_ready).
//  - Flags overrun when the bridge stalls on WSPACE==0; flags and discards framing errors.
// PARAMETERS
//  BAUD        115200    line bit rate
//  MAIN_CLK    50000000  clk frequency in Hz
//  OVERSAMPLE  16        ticks per bit; even, >=8
//  DIV is derived: (MAIN_CLK + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. rounded; 27 at defaults.
// PORTS
//  clk           in   1  main clock
//  reset         in   1  synchronous, active-high reset
//  uart_rx       in   1  async serial input, idle high
//  rx_req        out  1  byte valid; held until accepted
//  rx_ready      in   1  consumer accepts when rx_req&&rx_ready at a posedge
//  rx_data       out  8  received byte; stable while rx_req=1
//  rx_overrun    out  1  1-clk pulse: byte completed while rx_req pending, new byte dropped
//  rx_frame_err  out  1  1-clk pulse: stop bit sampled low, byte dropped
// BEHAVIOUR
//  Reset
//  - rx_req=0, rx_data=8'h00, rx_overrun=0, rx_frame_err=0.
//  - Synchronizer flops=1, state=WAIT_HIGH, counters=0.
//  Input and tick generation
//  - 2-FF synchronizer on uart_rx; all logic uses its output (rxs). Adds 2 clk latency.
//  - Tick = 1-clk pulse every DIV clks. The divider restarts at 0 on start-edge detect, so ticks are phase-aligned to the frame.
//  - tcnt counts ticks 0..OVERSAMPLE-1 within a bit.
//  Bit sampling
//  - Bit value = majority of rxs at ticks H-1, H, H+1, where H=OVERSAMPLE/2.
//  - The decision is taken at tick H+1.
//  FSM
//  - WAIT_HIGH: rxs must be high for OVERSAMPLE consecutive ticks, then go to IDLE. Any low restarts the count.
//  - IDLE: on rxs 1->0, go to START and clear the divider and tcnt.
//  - START: at the start-bit decision, 0 -> DATA with bitcnt=0; 1 -> IDLE (false start, nothing reported).
//  - DATA: at each decision, shift[bitcnt]=bit. At bit boundary (tcnt wraps) bitcnt++. After bit 7 -> STOP.
//  - STOP: at the stop-bit decision, 1 -> byte done, go to IDLE. Sampling continues mid-stop, so a back-to-back start edge is caught.
//  - STOP: at the stop-bit decision, 0 -> rx_frame_err pulse, byte dropped, go to WAIT_HIGH (break/garbage rejection).
//  Output handshake
//  - Byte done with rx_req=0: next clk rx_req=1, rx_data=shift.
//  - Byte done with rx_req=1 and no accept that cycle: rx_data keeps the old byte, new byte dropped, rx_overrun pulses next clk.
//  - Byte done in the same cycle as an accept: no overrun; the new byte loads and rx_req stays 1.
//  - Accept (rx_req&&rx_ready): rx_req=0 next clk unless a new byte loads in that same cycle.
//  - rx_ready may be high while rx_req=0; it is ignored then.
//  - Latency: rx_req rises ~9.5 bit times + 3 clk after the line falling edge.
//  Reset mid-frame
//  - Partial byte is discarded; state=WAIT_HIGH.
//  - Remaining bits of the interrupted frame cannot produce a byte unless the line idles a full bit first.
// TESTING (defaults: DIV=27, bit=432 clk)
//  1. Frame 0x55, rx_ready=1 -> rx_req high exactly 1 clk, rx_data=0x55, no error pulses.
//  2. Frames 0xA3 then 0x3C back-to-back, rx_ready=0 -> rx_data stays 0xA3, one rx_overrun pulse. Then rx_ready=1 -> rx_req drops, no second byte.
//  3. 100-clk low glitch on an idle line -> no rx_req, no errors, FSM back to IDLE. A following frame 0x81 is received correctly.
//  4. Frame 0x00 with stop=0, line then held low 20 bit times -> one rx_frame_err, no rx_req. After line high, frame 0x7E is received as 0x7E.
//  5. 1-clk inversion at tick H of every data bit of frame 0xC9 -> rx_data=0xC9 (majority vote).
//  6. Reset 1 clk during bit 2 of frame 0xFF, then idle 1 bit, then frame 0x5A -> no byte from 0xFF, rx_data=0x5A.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Byte handshake between the oversampling UART receiver and its consumer.
// The receiver drives the byte and event pulses; the consumer drives rx_ready.
interface uart_rx_sampler_if;
    logic       rx_req;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (output rx_req, rx_data, rx_overrun, rx_frame_err, input rx_ready);
    modport slave  (input rx_req, rx_data, rx_overrun, rx_frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 receiver with 3-sample majority vote per bit.
// Each byte is presented on a valid/ready pair, with overrun and framing-error pulses.
module uart_rx_sampler #(
    parameter int BAUD       = 115200,
    parameter int MAIN_CLK   = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    uart_rx_sampler_if.master rx
);
    localparam int DIV = (MAIN_CLK + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
    localparam int H   = OVERSAMPLE/2;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic            rx_s1, rxs, rxs_d;
    logic [DW-1:0]   dcnt;
    logic [TW-1:0]   tcnt, hcnt;
    logic            samp_a, samp_b;
    logic [7:0]      shift;
    logic [2:0]      bitcnt;
    logic            dec_done;
    logic            tick, decide, wrap, maj, fall;
    logic            restart, to_data, byte_done, frame_err;
    logic            accept;

    always_comb begin
        tick   = (dcnt == DW'(DIV-1));
        decide = tick && (tcnt == TW'(H+1));
        wrap   = tick && (tcnt == TW'(OVERSAMPLE-1));
        maj    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
        fall   = rxs_d & ~rxs;
        accept = rx.rx_req & rx.rx_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_HIGH;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        restart   = 1'b0;
        to_data   = 1'b0;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state)
            WAIT_HIGH: if (rxs && tick && hcnt == TW'(OVERSAMPLE-1)) state_n = IDLE;
            IDLE: if (fall) begin
                state_n = START;
                restart = 1'b1;
            end
            START: if (decide) begin
                state_n = maj ? IDLE : DATA;
                to_data = ~maj;
            end
            DATA: if (wrap && dec_done && bitcnt == 3'd7) state_n = STOP;
            STOP: if (decide) begin
                // A low stop bit usually means break or garbage: resync on a full idle bit.
                if (maj) begin
                    byte_done = 1'b1;
                    state_n   = IDLE;
                end else begin
                    frame_err = 1'b1;
                    state_n   = WAIT_HIGH;
                end
            end
            default: state_n = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
            dcnt     <= '0;
            tcnt     <= '0;
            hcnt     <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shift    <= '0;
            bitcnt   <= '0;
            dec_done <= 1'b0;
        end else begin
            rx_s1 <= uart_rx;
            rxs   <= rx_s1;
            rxs_d <= rxs;
            if (restart) begin
                dcnt <= '0;
                tcnt <= '0;
            end else if (tick) begin
                dcnt <= '0;
                tcnt <= wrap ? '0 : tcnt + TW'(1);
            end else begin
                dcnt <= dcnt + DW'(1);
            end
            if (tick && tcnt == TW'(H-1)) samp_a <= rxs;
            if (tick && tcnt == TW'(H))   samp_b <= rxs;
            if (state != WAIT_HIGH || !rxs) hcnt <= '0;
            else if (tick)                  hcnt <= hcnt + TW'(1);
            // The start bit's own boundary falls inside DATA, so only count bits already decided.
            if (to_data) begin
                bitcnt   <= '0;
                dec_done <= 1'b0;
            end else if (state == DATA) begin
                if (decide) begin
                    shift[bitcnt] <= maj;
                    dec_done      <= 1'b1;
                end else if (wrap && dec_done) begin
                    bitcnt   <= bitcnt + 3'd1;
                    dec_done <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx.rx_req       <= 1'b0;
            rx.rx_data      <= 8'h00;
            rx.rx_overrun   <= 1'b0;
            rx.rx_frame_err <= 1'b0;
        end else begin
            rx.rx_overrun   <= 1'b0;
            rx.rx_frame_err <= frame_err;
            if (byte_done && (!rx.rx_req || accept)) begin
                rx.rx_req  <= 1'b1;
                rx.rx_data <= shift;
            end else begin
                if (accept)    rx.rx_req     <= 1'b0;
                if (byte_done) rx.rx_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at default parameters (27 clk per tick, 432 clk per bit).
module tb_uart_rx_sampler;
    localparam int BIT = 432;
    localparam int GLITCH_OFF = 27*9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_rx = 1'b1;
    uart_rx_sampler_if bus();

    uart_rx_sampler dut (.clk(clk), .reset(reset), .uart_rx(uart_rx), .rx(bus));

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cyc = 0, acc_cnt = 0, ovr_cnt = 0, ferr_cnt = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (bus.rx_req) req_cyc++;
        if (bus.rx_req && bus.rx_ready) begin
            acc_cnt++;
            last_data = bus.rx_data;
        end
        if (bus.rx_overrun) ovr_cnt++;
        if (bus.rx_frame_err) ferr_cnt++;
    end

    task automatic drive_line(input logic v, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            uart_rx = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch, input int rst_cyc);
        for (int c = 0; c < 10*BIT; c++) begin
            int bi;
            logic v;
            bi = c / BIT;
            if (bi == 0)      v = 1'b0;
            else if (bi == 9) v = stop;
            else              v = b[bi-1];
            if (glitch && bi >= 1 && bi <= 8 && (c % BIT) == GLITCH_OFF) v = ~v;
            @(posedge clk); #1;
            uart_rx = v;
            reset = (c == rst_cyc);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus.rx_ready = 1'b0;
        reset = 1'b1;
        drive_line(1'b1, 3);
        n_tests++; if (bus.rx_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.rx_req); end
        n_tests++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
        n_tests++; if (bus.rx_overrun !== 1'b0 || bus.rx_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got ovr=%b ferr=%b expected 0 0", bus.rx_overrun, bus.rx_frame_err); end
        reset = 1'b0;
        drive_line(1'b1, 2*BIT);
    endtask

    task automatic test_single_byte;
        int r0, a0, o0, f0;
        bus.rx_ready = 1'b1;
        r0 = req_cyc; a0 = acc_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        drive_line(1'b1, 200);
        n_tests++; if (req_cyc - r0 !== 1) begin n_fail++; $display("FAIL single_req_cycles: got %0d expected 1", req_cyc - r0); end
        n_tests++; if (acc_cnt - a0 !== 1 || last_data !== 8'h55) begin
            n_fail++; $display("FAIL single_data: got n=%0d data=%h expected n=1 data=55", acc_cnt - a0, last_data); end
        n_tests++; if (ovr_cnt != o0 || ferr_cnt != f0) begin
            n_fail++; $display("FAIL single_pulses: got ovr=%0d ferr=%0d expected 0 0", ovr_cnt - o0, ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        int a0, o0;
        bus.rx_ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(8'hA3, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        drive_line(1'b1, 200);
        n_tests++; if (bus.rx_req !== 1'b1 || bus.rx_data !== 8'hA3) begin
            n_fail++; $display("FAIL b2b_hold: got req=%b data=%h expected req=1 data=a3", bus.rx_req, bus.rx_data); end
        n_tests++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 1", ovr_cnt - o0); end
        bus.rx_ready = 1'b1;
        drive_line(1'b1, 2);
        n_tests++; if (bus.rx_req !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got req=%b expected 0", bus.rx_req); end
        drive_line(1'b1, BIT);
        n_tests++; if (acc_cnt - a0 !== 1 || bus.rx_req !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_second: got acc=%0d req=%b expected acc=1 req=0", acc_cnt - a0, bus.rx_req); end
    endtask

    task automatic test_glitch;
        int r0, a0, o0, f0;
        bus.rx_ready = 1'b1;
        r0 = req_cyc; a0 = acc_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
        drive_line(1'b0, 100);
        drive_line(1'b1, BIT);
        n_tests++; if (req_cyc != r0 || ovr_cnt != o0 || ferr_cnt != f0) begin
            n_fail++; $display("FAIL glitch_quiet: got req=%0d ovr=%0d ferr=%0d expected 0 0 0", req_cyc - r0, ovr_cnt - o0, ferr_cnt - f0); end
        send_frame(8'h81, 1'b1, 1'b0, -1);
        drive_line(1'b1, 200);
        n_tests++; if (acc_cnt - a0 !== 1 || last_data !== 8'h81) begin
            n_fail++; $display("FAIL glitch_next: got n=%0d data=%h expected n=1 data=81", acc_cnt - a0, last_data); end
    endtask

    task automatic test_frame_err;
        int r0, a0, f0;
        bus.rx_ready = 1'b1;
        r0 = req_cyc; a0 = acc_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b0, 1'b0, -1);
        drive_line(1'b0, 20*BIT);
        n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - f0); end
        n_tests++; if (req_cyc != r0) begin n_fail++; $display("FAIL ferr_no_req: got %0d expected 0", req_cyc - r0); end
        drive_line(1'b1, 2*BIT);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        drive_line(1'b1, 200);
        n_tests++; if (acc_cnt - a0 !== 1 || last_data !== 8'h7E || ferr_cnt - f0 !== 1) begin
            n_fail++; $display("FAIL ferr_recover: got n=%0d data=%h ferr=%0d expected n=1 data=7e ferr=1", acc_cnt - a0, last_data, ferr_cnt - f0); end
    endtask

    task automatic test_majority;
        int f0;
        bus.rx_ready = 1'b0;
        f0 = ferr_cnt;
        send_frame(8'hC9, 1'b1, 1'b1, -1);
        drive_line(1'b1, 200);
        n_tests++; if (bus.rx_req !== 1'b1 || bus.rx_data !== 8'hC9 || ferr_cnt != f0) begin
            n_fail++; $display("FAIL majority: got req=%b data=%h ferr=%0d expected req=1 data=c9 ferr=0", bus.rx_req, bus.rx_data, ferr_cnt - f0); end
        bus.rx_ready = 1'b1;
        drive_line(1'b1, 2);
    endtask

    task automatic test_reset_mid_frame;
        int r0, a0;
        bus.rx_ready = 1'b1;
        r0 = req_cyc; a0 = acc_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, 3*BIT + 100);
        drive_line(1'b1, BIT);
        n_tests++; if (req_cyc != r0) begin n_fail++; $display("FAIL rst_mid_no_byte: got %0d expected 0", req_cyc - r0); end
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        drive_line(1'b1, 200);
        n_tests++; if (acc_cnt - a0 !== 1 || last_data !== 8'h5A) begin
            n_fail++; $display("FAIL rst_mid_next: got n=%0d data=%h expected n=1 data=5a", acc_cnt - a0, last_data); end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_majority;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
